fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv32_pkg.sv | 25 ++
 rtl/next_pc_sel.sv | 54 +++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared fetch-unit types, instruction encodings and width defaults
//
// Purpose: common definitions imported by fetch_unit and next_pc_sel.
// Contents:
//   DEFAULT_ADDR_WIDTH / DEFAULT_DATA_WIDTH : default PC and instruction widths
//   INSN_NOP / INSN_ECALL / INSN_EBREAK     : fixed RV32 encodings
//   fetch_state_t                           : fetch FSM state enum
package rv32_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [31:0] INSN_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - next-PC priority mux with alignment and ROM range check
//
// Purpose: pick the next fetch address (jump > branch > pc+4) and flag
// addresses that cannot be fetched (misaligned or past the end of the ROM).
// Ports:
//   i_pc              current PC
//   i_jump            unconditional redirect request
//   i_jump_target     jump destination
//   i_branch_taken    taken conditional branch
//   i_branch_target   branch destination
//   o_pc_plus4        i_pc + 4 (wraps)
//   o_next_pc         selected next PC
//   o_next_illegal    o_next_pc is misaligned or out of range
//   o_pc_illegal      i_pc itself is misaligned or out of range
module next_pc_sel
  import rv32_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ROM_WORDS  = 31
) (
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_jump,
  input  logic [ADDR_WIDTH-1:0] i_jump_target,
  input  logic                  i_branch_taken,
  input  logic [ADDR_WIDTH-1:0] i_branch_target,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  output logic [ADDR_WIDTH-1:0] o_next_pc,
  output logic                  o_next_illegal,
  output logic                  o_pc_illegal
);

  // One extra bit so the byte limit never aliases to a small value when the
  // ROM fills the whole address space.
  localparam logic [ADDR_WIDTH:0] PC_LIMIT = (ADDR_WIDTH + 1)'(4 * ROM_WORDS);

  function automatic logic pc_illegal(input logic [ADDR_WIDTH-1:0] pc);
    return (pc[1:0] != 2'b00) || ({1'b0, pc} >= PC_LIMIT);
  endfunction

  assign o_pc_plus4 = i_pc + ADDR_WIDTH'(4);

  always_comb begin
    o_next_pc = o_pc_plus4;
    if (i_jump) begin
      o_next_pc = i_jump_target;
    end else if (i_branch_taken) begin
      o_next_pc = i_branch_target;
    end
  end

  assign o_next_illegal = pc_illegal(o_next_pc);
  assign o_pc_illegal   = pc_illegal(i_pc);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with BOOT/RUN/HALT/FAULT control
//
// Purpose: owns the PC, presents the fetched instruction to decode, stops on
// ECALL/EBREAK, traps on unfetchable addresses, counts cycles and retires.
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   stall_i            hold PC and retire count this cycle
//   jump_i/_target_i   unconditional redirect (highest priority)
//   branch_taken_i/_target_i  taken conditional branch
//   instruction_i      instruction memory data at pc_o
//   pc_o, pc_plus4_o   current PC and its link value
//   instruction_o      instruction_i when valid_o, else NOP
//   valid_o            instruction_o is executable this cycle
//   halt_o, fault_o    terminal HALT / FAULT state
//   instret_o, cycle_o 64-bit retire and cycle counters
module fetch_unit
  import rv32_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    ROM_WORDS    = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  jump_i,
  input  logic [ADDR_WIDTH-1:0] jump_target_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic [DATA_WIDTH-1:0] instruction_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic                  valid_o,
  output logic                  halt_o,
  output logic                  fault_o,
  output logic [63:0]           instret_o,
  output logic [63:0]           cycle_o
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [63:0]           r_instret;
  logic [63:0]           r_cycle;

  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic                  w_next_illegal;
  logic                  w_pc_illegal;
  logic                  w_active;
  logic                  w_system_insn;
  logic                  w_retire;

  next_pc_sel #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ROM_WORDS  (ROM_WORDS)
  ) u_next_pc_sel (
    .i_pc            (r_pc),
    .i_jump          (jump_i),
    .i_jump_target   (jump_target_i),
    .i_branch_taken  (branch_taken_i),
    .i_branch_target (branch_target_i),
    .o_pc_plus4      (w_pc_plus4),
    .o_next_pc       (w_next_pc),
    .o_next_illegal  (w_next_illegal),
    .o_pc_illegal    (w_pc_illegal)
  );

  // A stalled cycle does nothing, so stall masks ECALL detection and the
  // next-PC legality check as well as the retire.
  assign w_active      = (r_state == ST_RUN) && !stall_i;
  assign w_system_insn = (instruction_i == DATA_WIDTH'(INSN_ECALL)) ||
                         (instruction_i == DATA_WIDTH'(INSN_EBREAK));
  assign w_retire      = w_active && !w_system_insn;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // The reset vector is trusted to be fetchable only if it passes the
      // same check as any other PC.
      ST_BOOT:  w_state_nxt = w_pc_illegal ? ST_FAULT : ST_RUN;
      ST_RUN: begin
        if (w_active) begin
          if (w_system_insn) begin
            w_state_nxt = ST_HALT;
          end else if (w_next_illegal) begin
            w_state_nxt = ST_FAULT;
          end
        end
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_FAULT;
    endcase
  end

  // Output logic
  always_comb begin
    valid_o       = w_active;
    halt_o        = (r_state == ST_HALT);
    fault_o       = (r_state == ST_FAULT);
    instruction_o = w_active ? instruction_i : DATA_WIDTH'(INSN_NOP);
  end

  // PC and counters. A faulting redirect still retires the instruction that
  // requested it; only the PC update is suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_VECTOR;
      r_instret <= '0;
      r_cycle   <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_retire) begin
        r_instret <= r_instret + 64'd1;
        if (!w_next_illegal) begin
          r_pc <= w_next_pc;
        end
      end
    end
  end

  assign pc_o       = r_pc;
  assign pc_plus4_o = w_pc_plus4;
  assign instret_o  = r_instret;
  assign cycle_o    = r_cycle;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
  import rv32_pkg::*;

  localparam int ROM = 31;
  localparam logic [31:0] LIMIT = 32'(4 * ROM);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_i = 1'b0, jump_i = 1'b0, branch_taken_i = 1'b0;
  logic [31:0] jump_target_i = '0, branch_target_i = '0, instruction_i = 32'h13;
  logic [31:0] pc_o, pc_plus4_o, instruction_o;
  logic        valid_o, halt_o, fault_o;
  logic [63:0] instret_o, cycle_o;
  logic [31:0] pc2, pc_plus4_2, instruction2;
  logic        valid2, halt2, fault2;
  logic [63:0] instret2, cycle2;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [63:0] m_instret, m_cycle;
  bit          m_boot, m_halt, m_fault;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h0), .ROM_WORDS(ROM)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i), .instruction_i(instruction_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .instruction_o(instruction_o), .valid_o(valid_o),
    .halt_o(halt_o), .fault_o(fault_o), .instret_o(instret_o), .cycle_o(cycle_o));

  // Misaligned reset vector: must fault straight out of BOOT.
  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h2), .ROM_WORDS(ROM)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i), .instruction_i(instruction_i),
    .pc_o(pc2), .pc_plus4_o(pc_plus4_2), .instruction_o(instruction2), .valid_o(valid2),
    .halt_o(halt2), .fault_o(fault2), .instret_o(instret2), .cycle_o(cycle2));

  task automatic model_reset();
    m_pc = 32'h0; m_instret = 64'd0; m_cycle = 64'd0;
    m_boot = 1'b1; m_halt = 1'b0; m_fault = 1'b0;
  endtask

  // One clock of architectural behaviour, from the inputs present at the edge.
  task automatic model_step();
    logic [31:0] nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_cycle = m_cycle + 64'd1;
    if (m_boot) begin
      m_boot = 1'b0;
      if (m_pc[1:0] != 2'b00 || m_pc >= LIMIT) m_fault = 1'b1;
    end else if (!m_halt && !m_fault && !stall_i) begin
      if (instruction_i == INSN_ECALL || instruction_i == INSN_EBREAK) begin
        m_halt = 1'b1;
      end else begin
        if (jump_i) nxt = jump_target_i;
        else if (branch_taken_i) nxt = branch_target_i;
        else nxt = m_pc + 32'd4;
        m_instret = m_instret + 64'd1;
        if (nxt % 4 != 0 || nxt >= LIMIT) m_fault = 1'b1;
        else m_pc = nxt;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit st, input bit j, input logic [31:0] jt,
                       input bit b, input logic [31:0] bt, input logic [31:0] ins);
    stall_i = st; jump_i = j; jump_target_i = jt;
    branch_taken_i = b; branch_target_i = bt; instruction_i = ins;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] v;
    v = $urandom;
    if (v == INSN_ECALL || v == INSN_EBREAK) v = INSN_NOP;
    return v;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [7:0] w;
    w = 8'($urandom_range(0, ROM - 1));
    if ($urandom_range(0, 9) < 8) return {22'h0, w, 2'b00};
    return $urandom;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, rand_insn());
  endtask

  // Plain sequential fetch for n clocks (the first one leaves BOOT).
  task automatic run_plain(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, rand_target(), 0, rand_target(), rand_insn());
      tick();
    end
  endtask

  task automatic test_reset();
    drive(0, 1, 32'h40, 1, 32'h20, INSN_ECALL);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h0); end
    n_checks++; if (pc_plus4_o !== 32'h4) begin n_fail++; $display("FAIL reset_pc4 got=%h exp=%h", pc_plus4_o, 32'h4); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    n_checks++; if (instruction_o !== INSN_NOP) begin n_fail++; $display("FAIL reset_insn got=%h exp=%h", instruction_o, INSN_NOP); end
    n_checks++; if (halt_o !== 1'b0 || fault_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", halt_o, fault_o); end
    n_checks++; if (instret_o !== 64'd0) begin n_fail++; $display("FAIL reset_instret got=%0d exp=0", instret_o); end
    @(posedge clk); #1;
    n_checks++; if (cycle_o !== 64'd0) begin n_fail++; $display("FAIL reset_cycle_held got=%0d exp=0", cycle_o); end
    model_reset();
  endtask

  task automatic test_boot_fault();
    reset_dut();
    n_checks++; if (pc2 !== 32'h2 || fault2 !== 1'b0 || valid2 !== 1'b0) begin n_fail++; $display("FAIL bootv_pre got=pc%h f%b v%b exp=pc2 f0 v0", pc2, fault2, valid2); end
    tick();
    n_checks++; if (fault2 !== 1'b1 || halt2 !== 1'b0) begin n_fail++; $display("FAIL bootv_fault got=f%b h%b exp=f1 h0", fault2, halt2); end
    n_checks++; if (pc2 !== 32'h2 || pc_plus4_2 !== 32'h6) begin n_fail++; $display("FAIL bootv_pc got=%h/%h exp=2/6", pc2, pc_plus4_2); end
    n_checks++; if (instret2 !== 64'd0 || cycle2 !== 64'd1 || instruction2 !== INSN_NOP) begin n_fail++; $display("FAIL bootv_cnt got=%0d/%0d/%h exp=0/1/%h", instret2, cycle2, instruction2, INSN_NOP); end
    // the legal-vector unit left BOOT normally at the same edge
    n_checks++; if (valid_o !== 1'b1 || fault_o !== 1'b0) begin n_fail++; $display("FAIL boot_run got=v%b f%b exp=v1 f0", valid_o, fault_o); end
  endtask

  task automatic test_sequential();
    reset_dut();
    n_checks++; if (valid_o !== 1'b0 || pc_o !== 32'h0 || cycle_o !== 64'd0) begin n_fail++; $display("FAIL seq_boot got=v%b pc%h c%0d exp=v0 pc0 c0", valid_o, pc_o, cycle_o); end
    for (int k = 0; k < 4; k++) begin
      run_plain(1);
      n_checks++; if (pc_o !== 32'(4 * k) || valid_o !== 1'b1) begin n_fail++; $display("FAIL seq_pc%0d got=%h v%b exp=%h v1", k, pc_o, valid_o, 32'(4 * k)); end
    end
    n_checks++; if (instret_o !== 64'd3 || cycle_o !== 64'd4) begin n_fail++; $display("FAIL seq_counts got=%0d/%0d exp=3/4", instret_o, cycle_o); end
  endtask

  task automatic test_jump_priority();
    reset_dut();
    run_plain(3);
    n_checks++; if (pc_o !== 32'h8) begin n_fail++; $display("FAIL jp_pre got=%h exp=8", pc_o); end
    drive(0, 1, 32'h40, 1, 32'h20, rand_insn());
    tick();
    n_checks++; if (pc_o !== 32'h40 || instret_o !== 64'd3) begin n_fail++; $display("FAIL jp_jump got=%h/%0d exp=40/3", pc_o, instret_o); end
    drive(0, 0, 32'h44, 1, 32'h20, rand_insn());
    tick();
    n_checks++; if (pc_o !== 32'h20 || pc_plus4_o !== 32'h24) begin n_fail++; $display("FAIL jp_branch got=%h/%h exp=20/24", pc_o, pc_plus4_o); end
  endtask

  task automatic test_stall();
    reset_dut();
    run_plain(5);
    n_checks++; if (pc_o !== 32'h10 || instret_o !== 64'd4 || cycle_o !== 64'd5) begin n_fail++; $display("FAIL st_pre got=%h/%0d/%0d exp=10/4/5", pc_o, instret_o, cycle_o); end
    // stall outranks ECALL and an illegal redirect in the same cycle
    drive(1, 1, 32'h22, 1, 32'h7C, INSN_ECALL);
    #1;
    n_checks++; if (valid_o !== 1'b0 || instruction_o !== INSN_NOP) begin n_fail++; $display("FAIL st_valid got=v%b %h exp=v0 %h", valid_o, instruction_o, INSN_NOP); end
    tick(); tick();
    n_checks++; if (pc_o !== 32'h10 || instret_o !== 64'd4 || cycle_o !== 64'd7) begin n_fail++; $display("FAIL st_hold got=%h/%0d/%0d exp=10/4/7", pc_o, instret_o, cycle_o); end
    n_checks++; if (halt_o !== 1'b0 || fault_o !== 1'b0) begin n_fail++; $display("FAIL st_flags got=%b%b exp=00", halt_o, fault_o); end
    run_plain(1);
    n_checks++; if (pc_o !== 32'h14 || instret_o !== 64'd5) begin n_fail++; $display("FAIL st_resume got=%h/%0d exp=14/5", pc_o, instret_o); end
  endtask

  task automatic test_ecall();
    reset_dut();
    run_plain(4);
    drive(0, 1, 32'h40, 0, 32'h0, INSN_ECALL);
    #1;
    n_checks++; if (valid_o !== 1'b1 || instruction_o !== INSN_ECALL) begin n_fail++; $display("FAIL ec_present got=v%b %h exp=v1 %h", valid_o, instruction_o, INSN_ECALL); end
    tick();
    n_checks++; if (halt_o !== 1'b1 || pc_o !== 32'hC || instret_o !== 64'd3) begin n_fail++; $display("FAIL ec_halt got=h%b %h/%0d exp=h1 c/3", halt_o, pc_o, instret_o); end
    run_plain(5);
    n_checks++; if (pc_o !== 32'hC || instret_o !== 64'd3 || valid_o !== 1'b0 || halt_o !== 1'b1) begin n_fail++; $display("FAIL ec_frozen got=%h/%0d v%b h%b exp=c/3 v0 h1", pc_o, instret_o, valid_o, halt_o); end
    n_checks++; if (cycle_o !== 64'd10) begin n_fail++; $display("FAIL ec_cycle got=%0d exp=10", cycle_o); end
    reset_dut();
    run_plain(1);
    drive(0, 0, 32'h0, 0, 32'h0, INSN_EBREAK);
    tick();
    n_checks++; if (halt_o !== 1'b1 || pc_o !== 32'h0 || instret_o !== 64'd0) begin n_fail++; $display("FAIL eb_halt got=h%b %h/%0d exp=h1 0/0", halt_o, pc_o, instret_o); end
  endtask

  task automatic test_fault();
    reset_dut();
    run_plain(2);
    drive(0, 0, 32'h0, 1, 32'h22, rand_insn());
    tick();
    n_checks++; if (fault_o !== 1'b1 || pc_o !== 32'h4 || instret_o !== 64'd2) begin n_fail++; $display("FAIL ft_misalign got=f%b %h/%0d exp=f1 4/2", fault_o, pc_o, instret_o); end
    drive(0, 1, 32'h8, 0, 32'h0, rand_insn());
    tick(); tick();
    n_checks++; if (pc_o !== 32'h4 || valid_o !== 1'b0 || instret_o !== 64'd2 || fault_o !== 1'b1) begin n_fail++; $display("FAIL ft_frozen got=%h v%b %0d f%b exp=4 v0 2 f1", pc_o, valid_o, instret_o, fault_o); end
    reset_dut();
    run_plain(1);
    drive(0, 0, 32'h0, 1, 32'h7C, rand_insn());
    tick();
    n_checks++; if (fault_o !== 1'b1 || pc_o !== 32'h0 || instret_o !== 64'd1) begin n_fail++; $display("FAIL ft_range got=f%b %h/%0d exp=f1 0/1", fault_o, pc_o, instret_o); end
    reset_dut();
    run_plain(1);
    drive(0, 1, 32'h78, 0, 32'h0, rand_insn());
    tick();
    n_checks++; if (fault_o !== 1'b0 || pc_o !== 32'h78) begin n_fail++; $display("FAIL ft_last_word got=f%b %h exp=f0 78", fault_o, pc_o); end
    run_plain(1);
    n_checks++; if (fault_o !== 1'b1 || pc_o !== 32'h78 || instret_o !== 64'd2) begin n_fail++; $display("FAIL ft_fallthru got=f%b %h/%0d exp=f1 78/2", fault_o, pc_o, instret_o); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    run_plain(7);
    n_checks++; if (pc_o !== 32'h18) begin n_fail++; $display("FAIL ar_pre got=%h exp=18", pc_o); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc_o !== 32'h0 || instret_o !== 64'd0 || cycle_o !== 64'd0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL ar_async got=%h/%0d/%0d v%b exp=0/0/0 v0", pc_o, instret_o, cycle_o, valid_o); end
    reset_dut();
    n_checks++; if (valid_o !== 1'b0 || pc_o !== 32'h0) begin n_fail++; $display("FAIL ar_boot got=v%b %h exp=v0 0", valid_o, pc_o); end
    run_plain(1);
    n_checks++; if (valid_o !== 1'b1 || cycle_o !== 64'd1) begin n_fail++; $display("FAIL ar_run got=v%b %0d exp=v1 1", valid_o, cycle_o); end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    bit          e_valid;
    reset_dut();
    for (int i = 0; i < 800; i++) begin
      if ((m_halt || m_fault) && $urandom_range(0, 3) == 0) reset_dut();
      ins = ($urandom_range(0, 24) == 0) ? (($urandom_range(0, 1) == 0) ? INSN_ECALL : INSN_EBREAK) : rand_insn();
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, rand_target(),
            $urandom_range(0, 4) == 0, rand_target(), ins);
      #1;
      e_valid = !m_boot && !m_halt && !m_fault && !stall_i;
      n_checks++; if (pc_o !== m_pc || pc_plus4_o !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_pc[%0d] got=%h/%h exp=%h", i, pc_o, pc_plus4_o, m_pc); end
      n_checks++; if (valid_o !== e_valid || instruction_o !== (e_valid ? ins : INSN_NOP)) begin n_fail++; $display("FAIL rnd_out[%0d] got=v%b %h exp=v%b", i, valid_o, instruction_o, e_valid); end
      n_checks++; if (halt_o !== m_halt || fault_o !== m_fault) begin n_fail++; $display("FAIL rnd_state[%0d] got=h%b f%b exp=h%b f%b", i, halt_o, fault_o, m_halt, m_fault); end
      n_checks++; if (instret_o !== m_instret || cycle_o !== m_cycle) begin n_fail++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, instret_o, cycle_o, m_instret, m_cycle); end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_boot_fault();
    test_sequential();
    test_jump_priority();
    test_stall();
    test_ecall();
    test_fault();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
